// File: rtl/bit_stream_pkg.sv
// Shared state encoding and character/command constants for the
// bit-stream sequencer.
package bit_stream_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SETTLE    = 2'd1,
        SEND_BITS = 2'd2,
        SEND_END  = 2'd3
    } state_e;

    localparam logic [7:0] CHAR_ZERO     = 8'h30;
    localparam logic [7:0] CHAR_END      = 8'h2A;
    localparam logic [6:0] CMD_CLEAR_IDX = 7'd126;
    localparam logic [6:0] CMD_FRAME_IDX = 7'd127;

    function automatic logic [7:0] bit_char(input logic b);
        return CHAR_ZERO | {7'd0, b};
    endfunction

endpackage

// File: rtl/bit_stream_sequencer_settle_timer.sv
// Reload-and-decrement counter: settled once SETTLE_CYCLES cycles have
// passed without a restart.
module settle_timer
    import bit_stream_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic clk_48mhz,
    input  logic reset,
    input  logic restart,
    output logic settled
);

    localparam int CW = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CW-1:0] RELOAD = CW'(SETTLE_CYCLES);

    logic [CW-1:0] r_count;

    always_ff @(posedge clk_48mhz) begin
        if (!reset) begin
            r_count <= RELOAD;
        end else if (restart) begin
            r_count <= RELOAD;
        end else if (r_count != '0) begin
            r_count <= r_count - CW'(1);
        end
    end

    assign settled = (r_count == '0);

endmodule

// File: rtl/bit_stream_sequencer.sv
// Decodes host command bytes into in_bits writes, snapshots out_bits once
// the inputs have settled, and streams the snapshot as ASCII plus '*'.
module bit_stream_sequencer
    import bit_stream_pkg::*;
#(
    parameter int IN_LEN        = 64,
    parameter int OUT_LEN       = 64,
    parameter int SETTLE_CYCLES = 4,
    parameter int AUTO_STREAM   = 1
) (
    input  logic               clk_48mhz,
    input  logic               reset,
    input  logic [7:0]         rx_data,
    input  logic               rx_valid,
    output logic               rx_ready,
    output logic [7:0]         tx_data,
    output logic               tx_valid,
    input  logic               tx_ready,
    output logic [IN_LEN-1:0]  in_bits,
    input  logic [OUT_LEN-1:0] out_bits,
    output logic               busy,
    output logic [15:0]        frame_count
);

    localparam int CW = (OUT_LEN > 1) ? $clog2(OUT_LEN) : 1;
    localparam logic [CW-1:0] LAST_CUR = CW'(OUT_LEN - 1);
    localparam logic [7:0] IN_LEN_W = 8'(IN_LEN);

    state_e             r_state;
    state_e             w_next;
    logic               r_rx_ready;
    logic               r_tx_valid;
    logic [7:0]         r_tx_data;
    logic [IN_LEN-1:0]  r_in_bits;
    logic [OUT_LEN-1:0] r_shadow;
    logic [CW-1:0]      r_cursor;
    logic               r_busy;
    logic               r_pending;
    logic [15:0]        r_frame_count;

    logic               w_rx_acc;
    logic               w_tx_acc;
    logic [6:0]         w_idx;
    logic               w_val;
    logic               w_idx_ok;
    logic               w_wr;
    logic               w_clr;
    logic               w_req;
    logic               w_in_write;
    logic               w_go;
    logic               w_restart;
    logic               w_settled;
    logic               w_snap;
    logic               w_last;
    logic [OUT_LEN-1:0] w_shift;

    assign w_rx_acc   = rx_valid & r_rx_ready;
    assign w_tx_acc   = r_tx_valid & tx_ready;
    assign w_idx      = rx_data[7:1];
    assign w_val      = rx_data[0];
    assign w_idx_ok   = ({1'b0, w_idx} < IN_LEN_W);
    assign w_in_write = w_wr | w_clr;
    assign w_go       = (AUTO_STREAM != 0) || r_pending;
    assign w_last     = (r_cursor == LAST_CUR);
    assign w_shift    = r_shadow >> 1;

    always_comb begin
        w_wr  = 1'b0;
        w_clr = 1'b0;
        w_req = 1'b0;
        if (w_rx_acc) begin
            unique case (1'b1)
                w_idx_ok:                 w_wr  = 1'b1;
                (w_idx == CMD_CLEAR_IDX): w_clr = 1'b1;
                (w_idx == CMD_FRAME_IDX): w_req = 1'b1;
                default: ;
            endcase
        end
    end

    // Entering SETTLE restarts the quiet window so every frame waits it out.
    assign w_restart = w_in_write | ((r_state == IDLE) & w_go);

    settle_timer #(
        .SETTLE_CYCLES(SETTLE_CYCLES)
    ) u_settle_timer (
        .clk_48mhz(clk_48mhz),
        .reset    (reset),
        .restart  (w_restart),
        .settled  (w_settled)
    );

    assign w_snap = (r_state == SETTLE) & w_settled & ~w_in_write;

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:      if (w_go) w_next = SETTLE;
            SETTLE:    if (w_snap) w_next = SEND_BITS;
            SEND_BITS: if (w_tx_acc && w_last) w_next = SEND_END;
            SEND_END:  if (w_tx_acc) w_next = IDLE;
            default:   w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_48mhz) begin
        if (!reset) begin
            r_state       <= IDLE;
            r_rx_ready    <= 1'b0;
            r_tx_valid    <= 1'b0;
            r_tx_data     <= 8'h00;
            r_in_bits     <= '0;
            r_shadow      <= '0;
            r_cursor      <= '0;
            r_busy        <= 1'b0;
            r_pending     <= 1'b0;
            r_frame_count <= 16'd0;
        end else begin
            r_state    <= w_next;
            r_busy     <= (w_next != IDLE);
            r_rx_ready <= 1'b1;
            // A request arriving in the snapshot cycle is kept for the next frame.
            r_pending  <= w_req | (r_pending & ~w_snap);

            if (w_clr) begin
                r_in_bits <= '0;
            end else if (w_wr) begin
                for (int i = 0; i < IN_LEN; i++) begin
                    if (w_idx == 7'(i)) r_in_bits[i] <= w_val;
                end
            end

            unique case (r_state)
                SETTLE: begin
                    if (w_snap) begin
                        r_shadow   <= out_bits;
                        r_cursor   <= '0;
                        r_tx_valid <= 1'b1;
                        r_tx_data  <= bit_char(out_bits[0]);
                    end
                end
                SEND_BITS: begin
                    if (w_tx_acc) begin
                        if (w_last) begin
                            r_tx_data <= CHAR_END;
                        end else begin
                            r_cursor  <= r_cursor + CW'(1);
                            r_shadow  <= w_shift;
                            r_tx_data <= bit_char(w_shift[0]);
                        end
                    end
                end
                SEND_END: begin
                    if (w_tx_acc) begin
                        r_tx_valid    <= 1'b0;
                        r_tx_data     <= 8'h00;
                        r_frame_count <= r_frame_count + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign rx_ready    = r_rx_ready;
    assign tx_valid    = r_tx_valid;
    assign tx_data     = r_tx_data;
    assign in_bits     = r_in_bits;
    assign busy        = r_busy;
    assign frame_count = r_frame_count;

endmodule
